// File: rtl/reciprocal_arbiter.sv
// Round-robin arbiter sharing one combinational reciprocal datapath between
// NREQ requesters. One operation is in flight at a time: the operand is
// registered into the shared unit, the result is captured one cycle later and
// held on the response bus until the owning requester accepts it.
//
// state    | meaning
// ST_IDLE  | no operation in flight; round-robin grant offered on req_ready
// ST_ISSUE | operand registered into shared datapath; result settling
// ST_DONE  | result captured; rsp_valid held until owner's rsp_ready
module reciprocal_arbiter #(
   parameter int NREQ = 2,
   parameter int M    = 12,
   parameter int N    = 12,
   parameter int W    = M + N
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_data,
   input  logic [NREQ-1:0]   req_abs,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_sat,
   output logic [W-1:0]      rcp_i_data,
   output logic              rcp_i_abs,
   input  logic [W-1:0]      rcp_o_data,
   input  logic              rcp_o_sat,
   output logic              busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PW-1:0]     r_owner;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     w_grant;
   logic              w_grant_hit;
   logic [PW:0]       w_sum;
   logic              w_accept;
   logic              w_rsp_take;
   logic [NREQ-1:0]   w_req_ready;
   logic [NREQ-1:0]   w_owner_1h;
   logic [NREQ-1:0]   r_rsp_valid;
   logic [W-1:0]      r_rsp_data;
   logic              r_rsp_sat;
   logic [W-1:0]      r_rcp_data;
   logic              r_rcp_abs;

   // Search for the first valid requester starting just after the last winner.
   always_comb begin
      w_grant_hit = 1'b0;
      w_grant     = '0;
      w_sum       = '0;
      for (int i = 1; i <= NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(NREQ)) begin
            w_sum = w_sum - (PW+1)'(NREQ);
         end
         if (!w_grant_hit && req_valid[w_sum[PW-1:0]]) begin
            w_grant_hit = 1'b1;
            w_grant     = w_sum[PW-1:0];
         end
      end
   end

   assign w_owner_1h = NREQ'(1) << r_owner;

   // Next state and handshake strobes; req_ready is only offered in IDLE and
   // is forced low while reset is asserted.
   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      w_accept    = 1'b0;
      w_rsp_take  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_hit && !reset) begin
               w_req_ready[w_grant] = 1'b1;
               w_accept             = 1'b1;
               w_state_nxt          = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (rsp_ready[r_owner]) begin
               w_rsp_take  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Operand launch, owner/pointer tracking, result capture and release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner     <= '0;
         r_ptr       <= PW'(NREQ - 1);
         r_rcp_data  <= '0;
         r_rcp_abs   <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_sat   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rcp_data <= req_data[w_grant*W +: W];
            r_rcp_abs  <= req_abs[w_grant];
            r_owner    <= w_grant;
            r_ptr      <= w_grant;
         end
         if (r_state == ST_ISSUE) begin
            r_rsp_data  <= rcp_o_data;
            r_rsp_sat   <= rcp_o_sat;
            r_rsp_valid <= w_owner_1h;
         end else if (w_rsp_take) begin
            r_rsp_valid <= '0;
         end
      end
   end

   assign req_ready  = w_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_sat    = r_rsp_sat;
   assign rcp_i_data = r_rcp_data;
   assign rcp_i_abs  = r_rcp_abs;
   assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reciprocal_arbiter.sv
// Bench for reciprocal_arbiter: a behavioural reciprocal stands in for the
// shared datapath, a transaction-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_reciprocal_arbiter;

   localparam int NREQ = 2;
   localparam int M    = 12;
   localparam int N    = 12;
   localparam int W    = M + N;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_abs;
   logic [NREQ-1:0]   rsp_valid;
   logic [NREQ-1:0]   rsp_ready;
   logic [W-1:0]      rsp_data;
   logic              rsp_sat;
   logic [W-1:0]      rcp_i_data;
   logic              rcp_i_abs;
   logic [W-1:0]      rcp_o_data;
   logic              rcp_o_sat;
   logic              busy;

   int total = 0;
   int bad   = 0;

   reciprocal_arbiter #(.NREQ(NREQ), .M(M), .N(N), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_data   (req_data),
      .req_abs    (req_abs),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_sat    (rsp_sat),
      .rcp_i_data (rcp_i_data),
      .rcp_i_abs  (rcp_i_abs),
      .rcp_o_data (rcp_o_data),
      .rcp_o_sat  (rcp_o_sat),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Q12.12 reciprocal: 1/x in raw units is 2^24 / raw, saturating to max positive.
   function automatic logic [W:0] rcp_fn(input logic [W-1:0] x, input logic ab);
      logic signed [W:0] sx;
      logic [W:0]        mag;
      logic [47:0]       q;
      logic [W-1:0]      d;
      logic              s;
      sx  = {x[W-1], x};
      mag = x[W-1] ? (-sx) : sx;
      s   = 1'b0;
      if (mag == '0) begin
         s = 1'b1;
         q = 48'h7FFFFF;
      end else begin
         q = 48'h1000000 / {23'd0, mag};
         if (q > 48'h7FFFFF) begin
            s = 1'b1;
            q = 48'h7FFFFF;
         end
      end
      d = q[W-1:0];
      if (x[W-1] && !ab) d = -d;
      return {s, d};
   endfunction

   assign {rcp_o_sat, rcp_o_data} = rcp_fn(rcp_i_data, rcp_i_abs);

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
      for (int i = 1; i <= NREQ; i++) begin
         int k;
         k = (ptr + i) % NREQ;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Transaction model: one op in flight, timed by edge counts since accept.
   int           cyc       = 0;
   bit           m_busy    = 1'b0;
   int           m_tacc    = 0;
   int           m_owner   = 0;
   int           m_ptr     = NREQ - 1;
   logic [W-1:0] m_op      = '0;
   logic         m_abs     = 1'b0;
   logic [W-1:0] m_rdata   = '0;
   logic         m_rsat    = 1'b0;
   int           m_g;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy  = 1'b0;
         m_owner = 0;
         m_ptr   = NREQ - 1;
         m_op    = '0;
         m_abs   = 1'b0;
         m_rdata = '0;
         m_rsat  = 1'b0;
      end else begin
         cyc++;
         if (!m_busy) begin
            m_g = rr_pick(req_valid, m_ptr);
            if (m_g >= 0) begin
               m_busy  = 1'b1;
               m_tacc  = cyc;
               m_owner = m_g;
               m_ptr   = m_g;
               m_op    = req_data[m_g*W +: W];
               m_abs   = req_abs[m_g];
            end
         end else if (cyc == m_tacc + 1) begin
            {m_rsat, m_rdata} = rcp_fn(m_op, m_abs);
         end else if (rsp_ready[m_owner]) begin
            m_busy = 1'b0;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   logic [NREQ-1:0] e_ready;
   logic [NREQ-1:0] e_valid;
   int              c_g;
   always @(negedge clk) begin
      e_ready = '0;
      if (!reset && !m_busy) begin
         c_g = rr_pick(req_valid, m_ptr);
         if (c_g >= 0) e_ready[c_g] = 1'b1;
      end
      e_valid = '0;
      if (m_busy && cyc >= m_tacc + 1) e_valid[m_owner] = 1'b1;
      chk("req_ready",  48'(req_ready),  48'(e_ready));
      chk("rsp_valid",  48'(rsp_valid),  48'(e_valid));
      chk("rsp_data",   48'(rsp_data),   48'(m_rdata));
      chk("rsp_sat",    48'(rsp_sat),    48'(m_rsat));
      chk("rcp_i_data", 48'(rcp_i_data), 48'(m_op));
      chk("rcp_i_abs",  48'(rcp_i_abs),  48'(m_abs));
      chk("busy",       48'(busy),       48'(m_busy));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Single op from requester k with immediate response acceptance.
   task automatic do_op(input int k, input logic [W-1:0] d, input logic a,
                        output logic [W-1:0] rd, output logic rs);
      bit seen;
      seen = 1'b0;
      rd   = '0;
      rs   = 1'b0;
      req_valid           = '0;
      req_valid[k]        = 1'b1;
      req_data[k*W +: W]  = d;
      req_abs[k]          = a;
      rsp_ready           = '1;
      step();
      req_valid[k] = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid[k]) begin
            seen = 1'b1;
            rd   = rsp_data;
            rs   = rsp_sat;
         end
         step();
      end
      chk("op_rsp_seen", 48'(seen), 48'd1);
      repeat (2) step();
   endtask

   logic [W-1:0]    r_d;
   logic            r_s;
   logic [NREQ-1:0] grants [4];
   int              ng;
   bit              got1;
   logic [W-1:0]    d1;

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_abs   = '0;
      rsp_ready = '0;
      step();
      step();
      @(negedge clk);
      chk("rst_rsp_valid", 48'(rsp_valid), 48'd0);
      chk("rst_req_ready", 48'(req_ready), 48'd0);
      step();
      reset = 1'b0;

      // 1.0 -> 1.0, two cycles after the handshake edge
      req_valid           = 2'b01;
      req_data[0*W +: W]  = 24'h001000;
      @(negedge clk);
      chk("t1_req_ready", 48'(req_ready), 48'h1);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("t1_issue_valid", 48'(rsp_valid), 48'h0);
      chk("t1_issue_busy",  48'(busy),      48'h1);
      step();
      rsp_ready = '1;
      @(negedge clk);
      chk("t1_rsp_valid", 48'(rsp_valid), 48'h1);
      chk("t1_rsp_data",  48'(rsp_data),  48'h001000);
      chk("t1_rsp_sat",   48'(rsp_sat),   48'h0);
      repeat (3) step();

      // both requesters held: alternating grants from req 0
      reset_pulse();
      req_valid          = 2'b11;
      req_data[0*W +: W] = 24'h001000;
      req_data[1*W +: W] = 24'h002000;
      req_abs            = '0;
      rsp_ready          = '1;
      ng   = 0;
      got1 = 1'b0;
      d1   = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready != '0 && ng < 4) begin
            grants[ng] = req_ready;
            ng++;
         end
         if (rsp_valid == 2'b10 && !got1) begin
            got1 = 1'b1;
            d1   = rsp_data;
         end
         step();
      end
      req_valid = '0;
      repeat (4) step();
      chk("t2_ngrants", 48'(ng), 48'd4);
      chk("t2_grant0", 48'(grants[0]), 48'h1);
      chk("t2_grant1", 48'(grants[1]), 48'h2);
      chk("t2_grant2", 48'(grants[2]), 48'h1);
      chk("t2_grant3", 48'(grants[3]), 48'h2);
      chk("t2_req1_rsp", 48'(d1), 48'h000800);

      // -2.0 signed and absolute
      do_op(1, 24'hFFE000, 1'b0, r_d, r_s);
      chk("t3_neg_data", 48'(r_d), 48'hFFF800);
      chk("t3_neg_sat",  48'(r_s), 48'h0);
      do_op(1, 24'hFFE000, 1'b1, r_d, r_s);
      chk("t3_abs_data", 48'(r_d), 48'h000800);

      // zero operand saturates
      do_op(0, 24'h000000, 1'b0, r_d, r_s);
      chk("t4_zero_sat",  48'(r_s), 48'h1);
      chk("t4_zero_data", 48'(r_d), 48'h7FFFFF);

      // response back-pressure with req1 waiting
      req_valid          = 2'b01;
      req_data[0*W +: W] = 24'h003000;
      req_data[1*W +: W] = 24'h004000;
      req_abs            = '0;
      rsp_ready          = '0;
      step();
      req_valid = 2'b10;
      @(negedge clk);
      chk("t5_issue_valid", 48'(rsp_valid), 48'h0);
      step();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", 48'(rsp_valid), 48'h1);
         chk("t5_hold_data",  48'(rsp_data),  48'h000555);
         chk("t5_hold_ready", 48'(req_ready), 48'h0);
         chk("t5_hold_busy",  48'(busy),      48'h1);
         step();
      end
      rsp_ready = 2'b01;
      step();
      @(negedge clk);
      chk("t5_req1_grant", 48'(req_ready), 48'h2);
      chk("t5_idle_busy",  48'(busy),      48'h0);
      rsp_ready = '1;
      step();
      req_valid = '0;
      @(negedge clk);
      chk("t5_req1_op", 48'(rcp_i_data), 48'h004000);
      repeat (4) step();

      // reset while an op is in ISSUE
      req_valid          = 2'b01;
      req_data[0*W +: W] = 24'h001000;
      step();
      req_valid = '0;
      #1;
      reset = 1'b1;
      #1;
      chk("t6_rst_valid",  48'(rsp_valid),  48'h0);
      chk("t6_rst_busy",   48'(busy),       48'h0);
      chk("t6_rst_data",   48'(rsp_data),   48'h0);
      chk("t6_rst_rcp",    48'(rcp_i_data), 48'h0);
      chk("t6_rst_ready",  48'(req_ready),  48'h0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t6_no_rsp", 48'(rsp_valid), 48'h0);
         step();
      end
      req_valid = 2'b11;
      @(negedge clk);
      chk("t6_req0_prio", 48'(req_ready), 48'h1);
      step();
      req_valid = '0;
      rsp_ready = '1;
      repeat (4) step();

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 399) == 0);
         req_valid = NREQ'($urandom);
         req_abs   = NREQ'($urandom);
         rsp_ready = NREQ'($urandom);
         for (int k = 0; k < NREQ; k++) begin
            case ($urandom_range(0, 3))
               0: req_data[k*W +: W] = W'($urandom);
               1: req_data[k*W +: W] = W'($urandom_range(0, 255)) ^ {W{$urandom_range(0, 1) == 1}};
               2: req_data[k*W +: W] = W'(24'h001000 << $urandom_range(0, 10));
               default: req_data[k*W +: W] = '0;
            endcase
         end
         step();
      end
      reset     = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
